// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// opcode patterns, error codes and parameter defaults.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Exact-match opcodes; ALU (1xxxxx) and LI (0001xx) are matched by prefix.
    localparam logic [5:0] OPC_NOP    = 6'b000000;
    localparam logic [5:0] OPC_J      = 6'b010000;
    localparam logic [5:0] OPC_JZ     = 6'b010001;
    localparam logic [5:0] OPC_JNZ    = 6'b010010;
    localparam logic [3:0] OPC_LI_PFX = 4'b0001;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int unsigned FETCH_TIMEOUT_DEF = 8;
    localparam int unsigned CNT_W_DEF         = 16;

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction decoder: maps the latched opcode and the live
// zero flag to datapath control signals, flagging opcodes outside the ISA.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] ir_op,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] Op,
    output logic       illegal
);

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        Op      = 3'b000;
        illegal = 1'b0;
        if (ir_op[5]) begin
            Op  = ir_op[4:2];
            we3 = 1'b1;
            wez = 1'b1;
        end else if (ir_op[5:2] == OPC_LI_PFX) begin
            s_inm = 1'b1;
            we3   = 1'b1;
        end else begin
            case (ir_op)
                OPC_NOP: s_inc = 1'b1;
                OPC_J:   s_inc = 1'b0;
                OPC_JZ:  s_inc = ~z;
                OPC_JNZ: s_inc = z;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_secuencial.sv
// Multicycle FETCH/EXEC control unit for the microc datapath, with fetch
// timeout, illegal-opcode halt and a saturating retired-instruction counter.
module uc_secuencial
    import uc_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             imem_ready,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_we,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [5:0]         ir_op_q, ir_op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_illegal;
    logic [2:0] dec_op;
    logic       timeout_hit;

    uc_decode u_decode (
        .ir_op   (ir_op_q),
        .z       (z),
        .s_inc   (dec_s_inc),
        .s_inm   (dec_s_inm),
        .we3     (dec_we3),
        .wez     (dec_wez),
        .Op      (dec_op),
        .illegal (dec_illegal)
    );

    // True on the not-ready cycle that would bring the wait count up to the limit.
    always_comb begin
        timeout_hit = (FETCH_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) >= FETCH_TIMEOUT);
    end

    always_comb begin
        state_d = state_q;
        ir_op_d = ir_op_q;
        wait_d  = wait_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_op_d = Opcode;
                    state_d = ST_EXEC;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (timeout_hit) begin
                        state_d = ST_HALT;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_op_q <= '0;
            wait_q  <= '0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls derive from the state register, so an asynchronous reset idles them at once.
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        pc_we = 1'b0;
        if (state_q == ST_EXEC) begin
            s_inc = dec_s_inc;
            s_inm = dec_s_inm;
            we3   = dec_we3;
            wez   = dec_wez;
            Op    = dec_op;
            pc_we = ~dec_illegal;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign err_code    = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_secuencial.sv
// Self-checking bench for uc_secuencial: directed scenarios followed by random
// instruction streams, compared every cycle against a behavioural model.
module tb_uc_secuencial;

    localparam int CW = 4;
    localparam int TO = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    Opcode = '0;
    logic          z = 1'b0;
    logic          imem_ready = 1'b0;
    logic          s_inc, s_inm, we3, wez, pc_we, halted;
    logic [2:0]    Op;
    logic [1:0]    err_code;
    logic [CW-1:0] instr_count;

    uc_secuencial #(.CNT_W(CW), .FETCH_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .z           (z),
        .imem_ready  (imem_ready),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .we3         (we3),
        .wez         (wez),
        .Op          (Op),
        .pc_we       (pc_we),
        .halted      (halted),
        .err_code    (err_code),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 = waiting for an instruction, 1 = executing, 2 = stopped.
    int         m_phase;
    logic [5:0] m_ir;
    int         m_wait;
    int         m_cnt;
    int         m_err;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       legal;
    } ctrl_t;

    function automatic ctrl_t ref_decode(input logic [5:0] opc, input logic zf);
        ctrl_t c;
        c = '0;
        c.s_inc = 1'b1;
        c.legal = 1'b1;
        if (opc >= 6'd32) begin
            c.op  = 3'((opc >> 2) & 6'd7);
            c.we3 = 1'b1;
            c.wez = 1'b1;
        end else if (opc == 6'd0) begin
            c.s_inc = 1'b1;
        end else if (opc >= 6'd4 && opc <= 6'd7) begin
            c.s_inm = 1'b1;
            c.we3   = 1'b1;
        end else if (opc == 6'd16) begin
            c.s_inc = 1'b0;
        end else if (opc == 6'd17) begin
            c.s_inc = !zf;
        end else if (opc == 6'd18) begin
            c.s_inc = zf;
        end else begin
            c.legal = 1'b0;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ir    = '0;
        m_wait  = 0;
        m_cnt   = 0;
        m_err   = 0;
    endtask

    task automatic check_outputs(input string tag);
        ctrl_t      c;
        logic       e_s_inc, e_s_inm, e_we3, e_wez, e_pc_we;
        logic [2:0] e_op;
        c = ref_decode(m_ir, z);
        e_s_inc = 1'b1;
        e_s_inm = 1'b0;
        e_we3   = 1'b0;
        e_wez   = 1'b0;
        e_op    = 3'b000;
        e_pc_we = 1'b0;
        if (m_phase == 1) begin
            e_s_inc = c.s_inc;
            e_s_inm = c.s_inm;
            e_we3   = c.we3;
            e_wez   = c.wez;
            e_op    = c.op;
            e_pc_we = c.legal;
        end
        chk({tag, "/s_inc"},  32'(s_inc),       32'(e_s_inc));
        chk({tag, "/s_inm"},  32'(s_inm),       32'(e_s_inm));
        chk({tag, "/we3"},    32'(we3),         32'(e_we3));
        chk({tag, "/wez"},    32'(wez),         32'(e_wez));
        chk({tag, "/Op"},     32'(Op),          32'(e_op));
        chk({tag, "/pc_we"},  32'(pc_we),       32'(e_pc_we));
        chk({tag, "/halted"}, 32'(halted),      32'(m_phase == 2));
        chk({tag, "/err"},    32'(err_code),    32'(m_err));
        chk({tag, "/count"},  32'(instr_count), 32'(m_cnt));
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model, cross the edge.
    task automatic step(input string tag, input logic rdy, input logic [5:0] opc, input logic zf);
        ctrl_t c;
        imem_ready = rdy;
        Opcode     = opc;
        z          = zf;
        #2;
        check_outputs(tag);
        case (m_phase)
            0: begin
                if (rdy) begin
                    m_ir    = opc;
                    m_phase = 1;
                end else begin
                    m_wait++;
                    if (m_wait >= TO) begin
                        m_phase = 2;
                        m_err   = 2;
                    end
                end
            end
            1: begin
                c = ref_decode(m_ir, zf);
                $display("[TB] %s exec op=%b z=%0d legal=%0d count_before=%0d",
                         tag, m_ir, zf, c.legal, m_cnt);
                if (c.legal) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_phase = 0;
                    m_wait  = 0;
                end else begin
                    m_phase = 2;
                    m_err   = 1;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 6)       return 6'(32 + $urandom_range(0, 31));
        else if (r < 8)  return 6'd0;
        else if (r < 11) return 6'(4 + $urandom_range(0, 3));
        else if (r < 13) return 6'd16;
        else if (r < 15) return 6'd17;
        else if (r < 17) return 6'd18;
        else             return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b1;

        // ALU instruction: Op = ir_op[4:2], writes to register file and flag.
        step("alu_f", 1'b1, 6'b100101, 1'b0);
        step("alu_x", 1'b1, 6'b100101, 1'b0);

        // LI, then JZ / JNZ / J under both flag values.
        step("li_f",   1'b1, 6'b000100, 1'b0);
        step("li_x",   1'b1, 6'b000100, 1'b0);
        step("jz1_f",  1'b1, 6'b010001, 1'b1);
        step("jz1_x",  1'b1, 6'b010001, 1'b1);
        step("jz0_f",  1'b1, 6'b010001, 1'b0);
        step("jz0_x",  1'b1, 6'b010001, 1'b0);
        step("jnz_f",  1'b1, 6'b010010, 1'b1);
        step("jnz_x",  1'b1, 6'b010010, 1'b1);
        step("j_f",    1'b1, 6'b010000, 1'b1);
        step("j_x",    1'b1, 6'b010000, 1'b1);

        // Opcode changing during EXEC must not affect the decode.
        step("chg_f",  1'b1, 6'b000000, 1'b0);
        step("chg_x",  1'b1, 6'b111111, 1'b0);

        // Five stalled fetch cycles, then the instruction proceeds.
        for (int i = 0; i < 5; i++) step("stall", 1'b0, 6'b100000, 1'b0);
        step("stall_f", 1'b1, 6'b100000, 1'b0);
        step("stall_x", 1'b1, 6'b100000, 1'b0);

        // Seven stalls, then ready on the cycle the limit would hit: ready wins.
        for (int i = 0; i < TO - 1; i++) step("edge", 1'b0, 6'b000000, 1'b0);
        step("edge_f", 1'b1, 6'b000101, 1'b0);
        step("edge_x", 1'b1, 6'b000101, 1'b0);

        // Enough NOPs to saturate the counter.
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            step("sat_f", 1'b1, 6'b000000, 1'b0);
            step("sat_x", 1'b1, 6'b000000, 1'b0);
        end

        // Illegal opcode halts; nothing moves it afterwards.
        step("ill_f", 1'b1, 6'b001000, 1'b0);
        step("ill_x", 1'b1, 6'b001000, 1'b0);
        for (int i = 0; i < 4; i++) step("ill_h", 1'b1, 6'b100001, 1'b1);
        do_reset("ill_rst");

        // Fetch timeout, then ready raised while halted.
        for (int i = 0; i < TO; i++) step("to", 1'b0, 6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) step("to_h", 1'b1, 6'b100000, 1'b0);
        do_reset("to_rst");

        // Reset asserted in the middle of an ALU EXEC cycle.
        step("mx_a_f", 1'b1, 6'b101110, 1'b0);
        step("mx_a_x", 1'b1, 6'b101110, 1'b0);
        step("mx_f",   1'b1, 6'b110011, 1'b0);
        imem_ready = 1'b1;
        #1;
        check_outputs("mx_pre");
        do_reset("mx_rst");
        step("mx_post", 1'b0, 6'b110011, 1'b0);
        step("mx_re_f", 1'b1, 6'b110011, 1'b0);
        step("mx_re_x", 1'b1, 6'b110011, 1'b1);

        // Random instruction streams with occasional stall bursts and resets.
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
                do_reset("rnd_rst");
            end else if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst_any");
            end else if ($urandom_range(0, 59) == 0) begin
                for (int k = 0; k < TO + 1; k++) step("rnd_burst", 1'b0, rand_op(), 1'($urandom_range(0, 1)));
            end else begin
                step("rnd", 1'($urandom_range(0, 3) != 0), rand_op(), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
